sbio_tx_arbiter: RTL and testbench
==================================

Name: sbio_tx_arbiter

Overview:
Console-side serial-bus transmitter. Arbitrates between three traffic sources: context scan-out, memory read request and sample out. Frames each accepted 16-bit word as start cycle + header cycle + payload cycles on tx_pins, which feed the off-chip context keeper's RX. Enforces a limit on transactions that are still awaiting a response (scan, read); responses are signalled back from the RX side.

Parameters:
IO_BITS, 2, pins per cycle; header and start-bit width.
PAYLOAD_CYCLES, 8, payload cycles per message; WORD_SIZE = PAYLOAD_CYCLES*IO_BITS = 16.
MAX_OUTSTANDING, 2, maximum unanswered scan+read messages; must be >= 1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
scan_valid  in  1  scan word available
scan_data  in  WORD_SIZE  scan word
scan_ready  out  1  scan word accepted this cycle
read_valid  in  1  read request available
read_data  in  WORD_SIZE  read address word
read_ready  out  1  read word accepted this cycle
out_valid  in  1  sample available
out_data  in  WORD_SIZE  sample word
out_ready  out  1  sample accepted this cycle
rsp_done  in  1  one-cycle pulse: a scan/read response fully received
tx_pins  out  IO_BITS  serial bus output
busy  out  1  message in flight (START/HEADER/PAYLOAD)
outstanding  out  $clog2(MAX_OUTSTANDING+1)  unanswered scan+read count
credit_error  out  1  sticky: rsp_done seen while outstanding==0

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Header codes: TX_SOURCE_SCAN=2'd0, TX_SOURCE_OUT=2'd1, TX_SOURCE_READ=2'd2.
- FSM states: IDLE, START, HEADER, PAYLOAD. A payload-cycle counter runs 0..PAYLOAD_CYCLES-1.
- tx_pins per state (combinational from registered state/shift register):
  - IDLE: 0
  - START: 2'b01
  - HEADER: latched header
  - PAYLOAD: shift_reg[IO_BITS-1:0], LSB-first, shifted right by IO_BITS each cycle.
- Eligibility:
  - out is always eligible.
  - scan and read are eligible only when outstanding < MAX_OUTSTANDING.
- Grant points:
  - in IDLE;
  - in the last PAYLOAD cycle (counter==PAYLOAD_CYCLES-1), so messages run back-to-back.
- Priority (default): out > read > scan.
- On grant:
  - exactly one *_ready is high for one cycle, combinationally in the grant cycle;
  - data and header are captured on that edge;
  - next state is START.
- Latency: valid high in IDLE at cycle N -> ready at N, START at N+1, HEADER at N+2, payload N+3..N+10.
- Message length is 2+PAYLOAD_CYCLES = 10 cycles. Back-to-back period is 10 cycles with no idle gap.
- After the last PAYLOAD cycle with no grant, the FSM returns to IDLE.
- *_ready is never high outside grant points. A source that drops valid without being granted is simply not served; there is no error.
- outstanding:
  - +1 on a scan/read grant; -1 on rsp_done.
  - Both in the same cycle: unchanged.
  - rsp_done at 0: counter stays 0 and credit_error is set (cleared only by reset).
  - Counting is independent of FSM state.
- busy = (state != IDLE).
- Reset, including mid-message: state IDLE, tx_pins=0 in the following cycle, outstanding=0, credit_error=0, all ready low, shift register don't-care. The aborted message is not resumed.

Optional Feature:
- Macro: SBIO_TX_ROUND_ROBIN_EN.
- Defined: replaces fixed priority with round-robin among eligible sources. A 2-bit last-grant pointer updates on each grant; search order starts after the last granted source; the pointer resets to scan. Ineligible sources are skipped.
- Undefined: fixed priority out > read > scan, and no pointer register exists.

Decomposition:
- Package sbio_pkg:
  - TX_SOURCE_SCAN/OUT/READ header constants;
  - RX_SB_SCAN/READ/WRITE start-bit constants;
  - tx_state_e enum {IDLE, START, HEADER, PAYLOAD};
  - source index typedef.
- Sub-module sbio_grant_select: combinational. Inputs are valid vector, eligibility vector and (optionally) last-grant pointer. Outputs are a one-hot grant and the header code. Used only at grant points.

Test Plan:
1. Single out word 16'hA5C3 in IDLE -> out_ready at N; tx_pins = 01, 01, then 3,0,0,3,1,1,2,2 (LSB-first 2-bit digits); IDLE after.
2. scan, read and out valid together in IDLE -> grant order out, read, scan (fixed); headers 1, 2, 0; messages contiguous, 30 cycles, no gap.
3. MAX_OUTSTANDING=2: three read requests, no rsp_done -> two sent, third held with read_ready low; rsp_done pulse -> third sent; outstanding trace 1,2,1,2.
4. Credit blocked by reads while out valid -> out still granted; rsp_done coinciding with a read grant -> outstanding unchanged.
5. rsp_done with outstanding=0 -> credit_error=1 and stays 1; reset asserted during a PAYLOAD cycle -> tx_pins=0 next cycle, busy=0, outstanding=0, credit_error=0.
6. With SBIO_TX_ROUND_ROBIN_EN, all three sources continuously valid -> header sequence 1,2,0,1,2,0 (after reset the pointer is at scan, so search starts at out).

Source files
------------

// File: rtl/sbio_pkg.sv
// Shared definitions for the serial-bus I/O transmit path: header codes,
// receiver start-bit symbols, transmitter state encoding and source index type.
package sbio_pkg;

    // Header codes sent in the HEADER cycle; also used as source indices
    localparam logic [1:0] TX_SOURCE_SCAN = 2'd0;
    localparam logic [1:0] TX_SOURCE_OUT  = 2'd1;
    localparam logic [1:0] TX_SOURCE_READ = 2'd2;

    // Start-bit symbols recognised by the receiving side
    localparam logic [1:0] RX_SB_SCAN  = 2'b01;
    localparam logic [1:0] RX_SB_READ  = 2'b10;
    localparam logic [1:0] RX_SB_WRITE = 2'b11;

    // Symbol driven on the pins during the START cycle
    localparam logic [1:0] TX_START_SYMBOL = 2'b01;

    localparam int NUM_SOURCES = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        HEADER,
        PAYLOAD
    } tx_state_e;

    typedef logic [1:0] src_idx_t;

endpackage

// File: rtl/sbio_grant_select.sv
// Combinational source selector for the serial-bus transmitter.
// Vectors are indexed by header code (bit0 scan, bit1 out, bit2 read).
// Default: fixed priority out > read > scan.
// With SBIO_TX_ROUND_ROBIN_EN defined: round-robin starting after last_grant.
module sbio_grant_select
    import sbio_pkg::*;
(
    input  logic [2:0] valid,
    input  logic [2:0] eligible,
`ifdef SBIO_TX_ROUND_ROBIN_EN
    input  src_idx_t   last_grant,
`endif
    output logic [2:0] grant,
    output src_idx_t   header
);

    logic [2:0] req;

    assign req = valid & eligible;

`ifdef SBIO_TX_ROUND_ROBIN_EN
    logic found;
    int   cand;

    // Search the sources in cyclic order beginning just after the last grant
    always_comb begin
        grant  = '0;
        header = TX_SOURCE_SCAN;
        found  = 1'b0;
        cand   = 0;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            cand = (int'(last_grant) + k) % NUM_SOURCES;
            if (!found && req[cand[1:0]]) begin
                grant[cand[1:0]] = 1'b1;
                header           = src_idx_t'(cand[1:0]);
                found            = 1'b1;
            end
        end
    end
`else
    // Fixed priority: sample output first, then read, then scan
    always_comb begin
        grant  = '0;
        header = TX_SOURCE_SCAN;
        if (req[TX_SOURCE_OUT]) begin
            grant[TX_SOURCE_OUT] = 1'b1;
            header               = TX_SOURCE_OUT;
        end else if (req[TX_SOURCE_READ]) begin
            grant[TX_SOURCE_READ] = 1'b1;
            header                = TX_SOURCE_READ;
        end else if (req[TX_SOURCE_SCAN]) begin
            grant[TX_SOURCE_SCAN] = 1'b1;
            header                = TX_SOURCE_SCAN;
        end
    end
`endif

endmodule

// File: rtl/sbio_tx_arbiter.sv
// Serial-bus transmitter: arbitrates scan-out, read requests and sample
// output, and frames each accepted word as START + HEADER + payload cycles.
// Scan and read messages consume a response credit returned by rsp_done.
// Optional macro SBIO_TX_ROUND_ROBIN_EN selects round-robin arbitration.
module sbio_tx_arbiter
    import sbio_pkg::*;
#(
    parameter  int IO_BITS         = 2,
    parameter  int PAYLOAD_CYCLES  = 8,
    parameter  int MAX_OUTSTANDING = 2,
    localparam int WORD_SIZE       = PAYLOAD_CYCLES * IO_BITS,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scan_valid,
    input  logic [WORD_SIZE-1:0] scan_data,
    output logic                 scan_ready,
    input  logic                 read_valid,
    input  logic [WORD_SIZE-1:0] read_data,
    output logic                 read_ready,
    input  logic                 out_valid,
    input  logic [WORD_SIZE-1:0] out_data,
    output logic                 out_ready,
    input  logic                 rsp_done,
    output logic [IO_BITS-1:0]   tx_pins,
    output logic                 busy,
    output logic [CNT_W-1:0]     outstanding,
    output logic                 credit_error
);

    localparam int              PCW       = (PAYLOAD_CYCLES > 1) ? $clog2(PAYLOAD_CYCLES) : 1;
    localparam logic [PCW-1:0]  LAST_BEAT = PCW'(PAYLOAD_CYCLES - 1);

    tx_state_e              state;
    tx_state_e              state_next;
    logic [PCW-1:0]         beat;
    logic [WORD_SIZE-1:0]   shift_reg;
    logic [IO_BITS-1:0]     header_reg;
    logic [WORD_SIZE-1:0]   grant_data;
    logic [2:0]             valid_vec;
    logic [2:0]             eligible_vec;
    logic [2:0]             sel_grant;
    logic [2:0]             grant;
    src_idx_t               sel_header;
    logic                   grant_point;
    logic                   any_grant;
    logic                   credit_ok;
    logic                   credit_take;

`ifdef SBIO_TX_ROUND_ROBIN_EN
    src_idx_t               last_grant;
`endif

    assign credit_ok   = (outstanding < CNT_W'(MAX_OUTSTANDING));
    // Grants happen only in IDLE or in the final payload beat (back-to-back)
    assign grant_point = !reset &&
                         ((state == IDLE) || ((state == PAYLOAD) && (beat == LAST_BEAT)));
    assign grant       = grant_point ? sel_grant : 3'b000;
    assign any_grant   = |grant;
    assign credit_take = grant[TX_SOURCE_SCAN] | grant[TX_SOURCE_READ];

    assign scan_ready  = grant[TX_SOURCE_SCAN];
    assign read_ready  = grant[TX_SOURCE_READ];
    assign out_ready   = grant[TX_SOURCE_OUT];
    assign busy        = (state != IDLE);

    // Build request and eligibility vectors indexed by header code
    always_comb begin
        valid_vec                    = '0;
        eligible_vec                 = '0;
        valid_vec[TX_SOURCE_SCAN]    = scan_valid;
        valid_vec[TX_SOURCE_OUT]     = out_valid;
        valid_vec[TX_SOURCE_READ]    = read_valid;
        eligible_vec[TX_SOURCE_SCAN] = credit_ok;
        eligible_vec[TX_SOURCE_OUT]  = 1'b1;
        eligible_vec[TX_SOURCE_READ] = credit_ok;
    end

    sbio_grant_select u_grant_select (
        .valid      (valid_vec),
        .eligible   (eligible_vec),
`ifdef SBIO_TX_ROUND_ROBIN_EN
        .last_grant (last_grant),
`endif
        .grant      (sel_grant),
        .header     (sel_header)
    );

`ifdef SBIO_TX_ROUND_ROBIN_EN
    // Remember the most recently granted source for the round-robin search
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= TX_SOURCE_SCAN;
        end else if (any_grant) begin
            last_grant <= sel_header;
        end
    end
`endif

    // Select the word belonging to the granted source
    always_comb begin
        grant_data = scan_data;
        if (grant[TX_SOURCE_OUT]) begin
            grant_data = out_data;
        end else if (grant[TX_SOURCE_READ]) begin
            grant_data = read_data;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one START, one HEADER, then PAYLOAD_CYCLES beats
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_grant) state_next = START;
            START:   state_next = HEADER;
            HEADER:  state_next = PAYLOAD;
            PAYLOAD: if (beat == LAST_BEAT) state_next = any_grant ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Payload beat counter, cleared in HEADER and advanced through PAYLOAD
    always_ff @(posedge clk) begin
        if (reset) begin
            beat <= '0;
        end else if (state == HEADER) begin
            beat <= '0;
        end else if (state == PAYLOAD) begin
            beat <= beat + PCW'(1);
        end
    end

    // Capture word and header on grant; shift LSB-first during payload
    always_ff @(posedge clk) begin
        if (any_grant) begin
            shift_reg  <= grant_data;
            header_reg <= IO_BITS'(sel_header);
        end else if (state == PAYLOAD) begin
            shift_reg  <= shift_reg >> IO_BITS;
        end
    end

    // Response credit tracking; a response with nothing outstanding is sticky-flagged
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding  <= '0;
            credit_error <= 1'b0;
        end else if (credit_take && !rsp_done) begin
            outstanding <= outstanding + CNT_W'(1);
        end else if (rsp_done && !credit_take) begin
            if (outstanding == '0) begin
                credit_error <= 1'b1;
            end else begin
                outstanding <= outstanding - CNT_W'(1);
            end
        end
    end

    // Pin driver decoded from the registered state
    always_comb begin
        tx_pins = '0;
        case (state)
            IDLE:    tx_pins = '0;
            START:   tx_pins = IO_BITS'(TX_START_SYMBOL);
            HEADER:  tx_pins = header_reg;
            PAYLOAD: tx_pins = shift_reg[IO_BITS-1:0];
            default: tx_pins = '0;
        endcase
    end

endmodule

// File: tb/tb_sbio_tx_arbiter.sv
// Self-checking bench for sbio_tx_arbiter: table-driven single messages,
// hand-written multi-cycle sequences, and a frame decoder feeding a scoreboard.
module tb_sbio_tx_arbiter;

    logic        clk;
    logic        reset;
    logic        scan_valid, read_valid, out_valid;
    logic [15:0] scan_data, read_data, out_data;
    logic        scan_ready, read_ready, out_ready;
    logic        rsp_done;
    logic [1:0]  tx_pins;
    logic        busy;
    logic [1:0]  outstanding;
    logic        credit_error;

    sbio_tx_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .scan_valid   (scan_valid),
        .scan_data    (scan_data),
        .scan_ready   (scan_ready),
        .read_valid   (read_valid),
        .read_data    (read_data),
        .read_ready   (read_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .rsp_done     (rsp_done),
        .tx_pins      (tx_pins),
        .busy         (busy),
        .outstanding  (outstanding),
        .credit_error (credit_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  hdr;
        logic [15:0] data;
    } exp_t;

    // src: 0 = out, 1 = read, 2 = scan; rdy is {out, read, scan}
    typedef struct {
        int          src;
        logic [15:0] data;
        logic [2:0]  rdy;
        logic [1:0]  hdr;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        tbl[5];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          frames = 0;

    logic [2:0]  s_rdy;
    logic [1:0]  s_tx;
    logic        s_busy;
    logic [1:0]  s_out;
    logic        s_cerr;
    logic        s_rst;

    int          dec_st = 0;
    logic [1:0]  dec_hdr;
    logic [15:0] dec_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int src, input logic v, input logic [15:0] d);
        case (src)
            0: begin out_valid  = v; out_data  = d; end
            1: begin read_valid = v; read_data = d; end
            default: begin scan_valid = v; scan_data = d; end
        endcase
    endtask

    // One clock: sample mid-cycle, decode frames into the scoreboard, step past the edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        s_rdy  = {out_ready, read_ready, scan_ready};
        s_tx   = tx_pins;
        s_busy = busy;
        s_out  = outstanding;
        s_cerr = credit_error;
        s_rst  = reset;
        cyc++;
        if (s_rst) begin
            dec_st = 0;
        end else if (dec_st == 0) begin
            if (s_tx == 2'b01) dec_st = 1;
        end else if (dec_st == 1) begin
            dec_hdr = s_tx;
            dec_st  = 2;
        end else begin
            dec_word[(dec_st-2)*2 +: 2] = s_tx;
            if (dec_st == 9) begin
                frames++;
                dec_st = 0;
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_frame", {14'd0, dec_hdr, dec_word}, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_hdr", dec_hdr, e.hdr);
                    chk("sb_data", dec_word, e.data);
                end
            end else begin
                dec_st++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rsp();
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (s_busy && n < 40);
        chk("idle_timeout", s_busy, 1'b0);
    endtask

    function automatic int rdy_code(input logic [2:0] r);
        case (r)
            3'b100:  return 1;
            3'b010:  return 2;
            3'b001:  return 0;
            default: return 7;
        endcase
    endfunction

    initial begin
        int          gcode[$];
        int          gcyc[$];
        int          busy_cnt;
        int          reads;
        int          trace[$];
        int          seen;
        int          f0;
        logic [1:0]  prev;
        logic [15:0] d;
        logic [1:0]  ep;

        tbl[0] = '{0, 16'hA5C3, 3'b100, 2'd1};
        tbl[1] = '{2, 16'h1234, 3'b001, 2'd0};
        tbl[2] = '{1, 16'hFFFF, 3'b010, 2'd2};
        tbl[3] = '{0, 16'h0000, 3'b100, 2'd1};
        tbl[4] = '{2, 16'h8001, 3'b001, 2'd0};

        reset = 1'b1;
        scan_valid = 0; read_valid = 0; out_valid = 0;
        scan_data = '0; read_data = '0; out_data = '0;
        rsp_done = 0;
        tick(); tick();
        out_valid = 1'b1;
        tick();
        chk("reset_ready", s_rdy, 3'b000);
        chk("reset_busy", s_busy, 1'b0);
        chk("reset_tx", s_tx, 2'b00);
        chk("reset_outstanding", s_out, 2'd0);
        chk("reset_credit_error", s_cerr, 1'b0);
        out_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Single messages with exact per-cycle pin trace
        foreach (tbl[i]) begin
            drive(tbl[i].src, 1'b1, tbl[i].data);
            tick();
            chk("tbl_ready", s_rdy, tbl[i].rdy);
            sb_q.push_back('{tbl[i].hdr, tbl[i].data});
            drive(tbl[i].src, 1'b0, ~tbl[i].data);
            d = tbl[i].data;
            for (int j = 0; j <= 10; j++) begin
                tick();
                if (j == 0)       ep = 2'b01;
                else if (j == 1)  ep = tbl[i].hdr;
                else if (j < 10)  ep = d[(j-2)*2 +: 2];
                else              ep = 2'b00;
                chk("tbl_pins", s_tx, ep);
            end
            chk("tbl_busy_end", s_busy, 1'b0);
            if (tbl[i].src != 0) begin
                chk("tbl_outstanding_up", s_out, 2'd1);
                pulse_rsp();
                tick();
                chk("tbl_outstanding_down", s_out, 2'd0);
            end
        end

        // All three sources at once: fixed priority, back-to-back, no gap
        drive(0, 1'b1, 16'h0F0F);
        drive(1, 1'b1, 16'h3C3C);
        drive(2, 1'b1, 16'hC001);
        sb_q.push_back('{2'd1, 16'h0F0F});
        sb_q.push_back('{2'd2, 16'h3C3C});
        sb_q.push_back('{2'd0, 16'hC001});
        busy_cnt = 0;
        f0 = frames;
        for (int n = 0; n < 35; n++) begin
            tick();
            if (s_busy) busy_cnt++;
            if (s_rdy != 3'b000) begin
                gcode.push_back(rdy_code(s_rdy));
                gcyc.push_back(cyc);
                if (s_rdy[2]) out_valid = 1'b0;
                if (s_rdy[1]) read_valid = 1'b0;
                if (s_rdy[0]) scan_valid = 1'b0;
            end
        end
        chk("prio_grants", gcode.size(), 3);
        if (gcode.size() == 3) begin
            chk("prio_first", gcode[0], 1);
            chk("prio_second", gcode[1], 2);
            chk("prio_third", gcode[2], 0);
            chk("b2b_gap1", gcyc[1] - gcyc[0], 10);
            chk("b2b_gap2", gcyc[2] - gcyc[1], 10);
        end
        chk("b2b_busy_cycles", busy_cnt, 30);
        chk("b2b_frames", frames - f0, 3);
        chk("prio_outstanding", s_out, 2'd2);
        pulse_rsp();
        pulse_rsp();
        tick();
        chk("prio_outstanding_clear", s_out, 2'd0);

        // Credit limit: third read held until a response returns
        read_valid = 1'b1;
        read_data  = 16'h1111;
        sb_q.push_back('{2'd2, 16'h1111});
        sb_q.push_back('{2'd2, 16'h2222});
        sb_q.push_back('{2'd2, 16'h3333});
        reads = 0;
        seen  = 0;
        prev  = 2'd0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (s_out != prev) begin trace.push_back(int'(s_out)); prev = s_out; end
            if (s_rdy[1]) begin
                reads++;
                read_data = (reads == 1) ? 16'h2222 : 16'h3333;
            end
            if (n >= 25 && s_rdy[1]) seen++;
        end
        chk("credit_reads_sent", reads, 2);
        chk("credit_held_ready", seen, 0);
        chk("credit_full", s_out, 2'd2);
        rsp_done = 1'b1;
        tick();
        if (s_out != prev) begin trace.push_back(int'(s_out)); prev = s_out; end
        rsp_done = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (s_out != prev) begin trace.push_back(int'(s_out)); prev = s_out; end
            if (s_rdy[1]) begin reads++; read_valid = 1'b0; end
        end
        chk("credit_third_read", reads, 3);
        chk("credit_trace_len", trace.size(), 4);
        if (trace.size() == 4) begin
            chk("credit_trace0", trace[0], 1);
            chk("credit_trace1", trace[1], 2);
            chk("credit_trace2", trace[2], 1);
            chk("credit_trace3", trace[3], 2);
        end

        // Credit-blocked read does not block sample output
        wait_idle();
        drive(1, 1'b1, 16'hDEAD);
        drive(0, 1'b1, 16'h5A5A);
        sb_q.push_back('{2'd1, 16'h5A5A});
        tick();
        chk("blocked_out_granted", s_rdy, 3'b100);
        out_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (s_rdy[1]) seen++;
        end
        chk("blocked_read_held", seen, 0);
        read_valid = 1'b0;
        pulse_rsp();
        tick();
        chk("blocked_outstanding_one", s_out, 2'd1);
        // Response and read grant in the same cycle leave the count unchanged
        drive(1, 1'b1, 16'hBEEF);
        rsp_done = 1'b1;
        sb_q.push_back('{2'd2, 16'hBEEF});
        tick();
        chk("coincide_read_ready", s_rdy, 3'b010);
        read_valid = 1'b0;
        rsp_done = 1'b0;
        tick();
        chk("coincide_outstanding", s_out, 2'd1);
        wait_idle();
        pulse_rsp();
        tick();
        chk("coincide_clear", s_out, 2'd0);

        // Response with nothing outstanding sets the sticky error
        pulse_rsp();
        tick();
        chk("cerr_set", s_cerr, 1'b1);
        chk("cerr_count_floor", s_out, 2'd0);
        for (int n = 0; n < 5; n++) tick();
        chk("cerr_sticky", s_cerr, 1'b1);

        // Reset in the middle of a payload aborts the message
        drive(1, 1'b1, 16'h7777);
        tick();
        chk("abort_grant", s_rdy, 3'b010);
        read_valid = 1'b0;
        for (int n = 0; n < 5; n++) tick();
        chk("abort_busy_before", s_busy, 1'b1);
        chk("abort_outstanding_before", s_out, 2'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
        tick();
        chk("abort_tx", s_tx, 2'b00);
        chk("abort_busy", s_busy, 1'b0);
        chk("abort_outstanding", s_out, 2'd0);
        chk("abort_cerr", s_cerr, 1'b0);
        f0 = frames;
        for (int n = 0; n < 12; n++) tick();
        chk("abort_not_resumed", frames - f0, 0);
        chk("abort_still_idle", s_busy, 1'b0);

`ifdef SBIO_TX_ROUND_ROBIN_EN
        // Round-robin with all sources continuously valid
        gcode.delete();
        drive(0, 1'b1, 16'h0101);
        drive(1, 1'b1, 16'h0202);
        drive(2, 1'b1, 16'h0303);
        for (int k = 0; k < 2; k++) begin
            sb_q.push_back('{2'd1, 16'h0101});
            sb_q.push_back('{2'd2, 16'h0202});
            sb_q.push_back('{2'd0, 16'h0303});
        end
        for (int n = 0; n < 80 && gcode.size() < 6; n++) begin
            tick();
            rsp_done = 1'b0;
            if (s_rdy != 3'b000) begin
                gcode.push_back(rdy_code(s_rdy));
                if (!s_rdy[2]) rsp_done = 1'b1;
            end
        end
        out_valid = 1'b0; read_valid = 1'b0; scan_valid = 1'b0;
        tick();
        rsp_done = 1'b0;
        chk("rr_grants", gcode.size(), 6);
        if (gcode.size() == 6) begin
            chk("rr_0", gcode[0], 1);
            chk("rr_1", gcode[1], 2);
            chk("rr_2", gcode[2], 0);
            chk("rr_3", gcode[3], 1);
            chk("rr_4", gcode[4], 2);
            chk("rr_5", gcode[5], 0);
        end
        wait_idle();
`endif

        for (int n = 0; n < 3; n++) tick();
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
